// File: rtl/dcm_seq_pkg.sv
// Shared encodings for the DCM reset sequencer.
// State codes, status bit positions and counter sizing.
package dcm_seq_pkg;

    typedef enum logic [2:0] {
        DCM_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        SETTLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_e;

    localparam int STAT_CLKIN_STOP = 1;
    localparam int STAT_CLKFX_STOP = 2;
    localparam int SYNC_W          = 3;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
// Resets to zero so every monitored bit starts "not locked / no fault".
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] meta_d;
    logic [WIDTH-1:0] sync_d;

    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/dcm_reset_sequencer.sv
// Brings up the board DCM and derives the system reset from its lock.
// Runs entirely on the board input clock, independent of DCM outputs.
module dcm_reset_sequencer
    import dcm_seq_pkg::*;
#(
    parameter int RST_CYCLES    = 8,
    parameter int LOCK_TIMEOUT  = 1048575,
    parameter int SETTLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 15
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       restart_i,
    input  logic       dcm_locked_i,
    input  logic [7:0] dcm_status_i,
    output logic       dcm_rst_o,
    output logic       sys_rst_o,
    output logic       locked_o,
    output logic       fail_o,
    output logic [3:0] retries_o
);

    localparam int CNT_W =
        cnt_width(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t RST_LAST = cnt_t'(RST_CYCLES - 1);
    localparam cnt_t TO_LAST  = cnt_t'(LOCK_TIMEOUT - 1);
    localparam cnt_t SET_LAST = cnt_t'(SETTLE_CYCLES - 1);
    localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRIES);

    logic [SYNC_W-1:0] sync_d;
    logic [SYNC_W-1:0] sync_s;
    logic              lock_s;
    logic              clkin_stop_s;
    logic              clkfx_stop_s;
    logic              dcm_ok;
    logic              unused_status;

    state_e     state_q;
    state_e     state_d;
    cnt_t       cnt_q;
    cnt_t       cnt_d;
    logic [3:0] retries_q;
    logic [3:0] retries_d;
    logic       retry;

    logic dcm_rst_q;
    logic dcm_rst_d;
    logic sys_rst_q;
    logic sys_rst_d;
    logic locked_q;
    logic locked_d;
    logic fail_q;
    logic fail_d;

    assign sync_d = {dcm_status_i[STAT_CLKFX_STOP],
                     dcm_status_i[STAT_CLKIN_STOP],
                     dcm_locked_i};

    assign unused_status = ^{dcm_status_i[7:3], dcm_status_i[0]};

    sync_2ff #(
        .WIDTH(SYNC_W)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .d_i    (sync_d),
        .q_o    (sync_s)
    );

    assign lock_s       = sync_s[0];
    assign clkin_stop_s = sync_s[1];
    assign clkfx_stop_s = sync_s[2];
    assign dcm_ok       = lock_s & ~clkin_stop_s & ~clkfx_stop_s;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        retries_d = retries_q;
        retry     = 1'b0;

        if (restart_i) begin
            state_d   = DCM_RST;
            cnt_d     = '0;
            retries_d = '0;
        end else begin
            unique case (state_q)
                DCM_RST: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end
                end
                WAIT_LOCK: begin
                    // A lock seen on the timeout cycle still wins.
                    if (dcm_ok) begin
                        state_d = SETTLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TO_LAST) begin
                        retry = 1'b1;
                    end
                end
                SETTLE: begin
                    if (!dcm_ok) begin
                        retry = 1'b1;
                    end else if (cnt_q == SET_LAST) begin
                        state_d   = RUN;
                        cnt_d     = '0;
                        retries_d = '0;
                    end
                end
                RUN: begin
                    cnt_d = cnt_q;
                    if (!dcm_ok) begin
                        state_d = DCM_RST;
                        cnt_d   = '0;
                    end
                end
                FAIL: begin
                    cnt_d = cnt_q;
                end
                default: begin
                    state_d = DCM_RST;
                    cnt_d   = '0;
                end
            endcase

            if (retry) begin
                cnt_d = '0;
                if (retries_q != RETRY_MAX) begin
                    retries_d = retries_q + 4'd1;
                end
                state_d = (retries_d == RETRY_MAX) ? FAIL : DCM_RST;
            end
        end

        // Outputs are registered from the next state.
        dcm_rst_d = (state_d == DCM_RST);
        sys_rst_d = (state_d != RUN);
        locked_d  = (state_d == RUN);
        fail_d    = (state_d == FAIL);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= DCM_RST;
            cnt_q     <= '0;
            retries_q <= '0;
            dcm_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            locked_q  <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retries_q <= retries_d;
            dcm_rst_q <= dcm_rst_d;
            sys_rst_q <= sys_rst_d;
            locked_q  <= locked_d;
            fail_q    <= fail_d;
        end
    end

    assign dcm_rst_o = dcm_rst_q;
    assign sys_rst_o = sys_rst_q;
    assign locked_o  = locked_q;
    assign fail_o    = fail_q;
    assign retries_o = retries_q;

endmodule

// File: tb/tb_dcm_reset_sequencer.sv
// Bench for dcm_reset_sequencer: phase/age reference model plus
// directed bring-up, retry, fault and reset scenarios, then random.
module tb_dcm_reset_sequencer;

    localparam int RC = 4;
    localparam int TO = 32;
    localparam int SC = 8;
    localparam int MR = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       restart = 1'b0;
    logic       locked = 1'b0;
    logic [7:0] status = 8'h00;
    logic       dcm_rst_o;
    logic       sys_rst_o;
    logic       locked_o;
    logic       fail_o;
    logic [3:0] retries_o;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    dcm_reset_sequencer #(
        .RST_CYCLES   (RC),
        .LOCK_TIMEOUT (TO),
        .SETTLE_CYCLES(SC),
        .MAX_RETRIES  (MR)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .restart_i   (restart),
        .dcm_locked_i(locked),
        .dcm_status_i(status),
        .dcm_rst_o   (dcm_rst_o),
        .sys_rst_o   (sys_rst_o),
        .locked_o    (locked_o),
        .fail_o      (fail_o),
        .retries_o   (retries_o)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: phase plus completed cycles in that phase.
    // The DCM is observed through a two-sample delay line.
    typedef enum int {P_PULSE, P_WAIT, P_SETTLE, P_RUN, P_FAIL} phase_e;

    typedef struct packed {
        phase_e   ph;
        int       age;
        int       tries;
        bit       lk_old;
        bit       lk_new;
        bit [1:0] st_old;
        bit [1:0] st_new;
    } mdl_t;

    mdl_t m = '0;

    function automatic mdl_t advance(input mdl_t cur, input bit lk,
                                     input bit [1:0] st, input bit rs);
        mdl_t n;
        bit   healthy;
        bit   miss;
        n       = cur;
        healthy = cur.lk_old && (cur.st_old == 2'b00);
        miss    = 1'b0;
        n.age   = cur.age + 1;
        if (rs) begin
            n.ph    = P_PULSE;
            n.age   = 0;
            n.tries = 0;
        end else begin
            case (cur.ph)
                P_PULSE:
                    if (n.age == RC) begin n.ph = P_WAIT; n.age = 0; end
                P_WAIT:
                    if (healthy) begin n.ph = P_SETTLE; n.age = 0; end
                    else if (n.age == TO) miss = 1'b1;
                P_SETTLE:
                    if (!healthy) miss = 1'b1;
                    else if (n.age == SC) begin
                        n.ph = P_RUN; n.age = 0; n.tries = 0;
                    end
                P_RUN:
                    if (!healthy) begin n.ph = P_PULSE; n.age = 0; end
                default: ;
            endcase
            if (miss) begin
                n.tries = (cur.tries + 1 > MR) ? MR : cur.tries + 1;
                n.ph    = (n.tries == MR) ? P_FAIL : P_PULSE;
                n.age   = 0;
            end
        end
        n.lk_old = cur.lk_new;
        n.lk_new = lk;
        n.st_old = cur.st_new;
        n.st_new = st;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= advance(m, locked, status[2:1], restart);
    end

    logic [7:0] exp_v;
    logic [7:0] act_v;

    always @(negedge clk) begin
        exp_v = {m.ph == P_PULSE, m.ph != P_RUN, m.ph == P_RUN,
                 m.ph == P_FAIL, 4'(m.tries)};
        act_v = {dcm_rst_o, sys_rst_o, locked_o, fail_o, retries_o};
        check("cycle_vs_model", int'(act_v), int'(exp_v));
    end

    function automatic bit sig(input int w);
        case (w)
            0:       return dcm_rst_o;
            1:       return sys_rst_o;
            2:       return locked_o;
            default: return fail_o;
        endcase
    endfunction

    task automatic wait_sig(input int w, input bit v, input int lim,
                            input string name, output int n);
        n = 0;
        while (sig(w) != v && n < lim) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(sig(w)), int'(v));
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              int'({dcm_rst_o, sys_rst_o, locked_o, fail_o, retries_o}),
              int'(8'b1100_0000));

        // Nominal bring-up.
        rst_n = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (!dcm_rst_o) break;
            n++;
            @(negedge clk);
        end
        check("dcm_rst_width", n, RC);
        repeat (6) @(negedge clk);
        locked = 1'b1;
        wait_sig(1, 1'b0, 60, "nominal_release", n);
        check("nominal_latency", n, 2 + SC + 1);
        check("nominal_locked", int'(locked_o), 1);
        check("nominal_retries", int'(retries_o), 0);

        // Lock loss in RUN.
        locked = 1'b0;
        wait_sig(1, 1'b1, 10, "loss_sys_rst", n);
        check("loss_latency", n, 3);
        check("loss_locked_o", int'(locked_o), 0);
        check("loss_retries", int'(retries_o), 0);
        wait_sig(0, 1'b0, 10, "loss_pulse_end", n);
        check("loss_pulse_width", n, RC);
        locked = 1'b1;
        wait_sig(2, 1'b1, 80, "relock_run", n);

        // Timeout retries into FAIL.
        locked = 1'b0;
        wait_sig(0, 1'b1, 10, "to_first_pulse", n);
        wait_sig(0, 1'b0, 10, "to_pulse_end", n);
        wait_sig(0, 1'b1, 60, "to_retry1", n);
        check("to_window", n, TO);
        check("to_retries1", int'(retries_o), 1);
        wait_sig(0, 1'b0, 10, "to_pulse2_end", n);
        check("to_pulse2_width", n, RC);
        wait_sig(0, 1'b1, 60, "to_retry2", n);
        check("to_retries2", int'(retries_o), 2);
        wait_sig(3, 1'b1, 60, "fail_entry", n);
        check("fail_entry_time", n, RC + TO);
        check("fail_retries", int'(retries_o), MR);
        check("fail_dcm_rst", int'(dcm_rst_o), 0);
        repeat (40) @(negedge clk);
        check("fail_sticky", int'(fail_o), 1);
        pulse_restart();
        check("restart_dcm_rst", int'(dcm_rst_o), 1);
        check("restart_retries", int'(retries_o), 0);
        check("restart_fail", int'(fail_o), 0);

        // CLKIN stop in SETTLE, CLKFX stop in RUN.
        locked = 1'b1;
        repeat (6) @(negedge clk);
        status = 8'h02;
        wait_sig(0, 1'b1, 8, "clkin_retry", n);
        check("clkin_retries", int'(retries_o), 1);
        status = 8'h00;
        wait_sig(2, 1'b1, 80, "clkin_recover", n);
        check("clkin_recover_retries", int'(retries_o), 0);
        status = 8'h04;
        wait_sig(1, 1'b1, 8, "clkfx_sys_rst", n);
        check("clkfx_latency", n, 3);
        check("clkfx_dcm_rst", int'(dcm_rst_o), 1);
        check("clkfx_retries", int'(retries_o), 0);
        status = 8'h00;
        wait_sig(2, 1'b1, 80, "clkfx_recover", n);

        // Asynchronous reset during SETTLE.
        pulse_restart();
        repeat (7) @(negedge clk);
        check("settle_dcm_rst", int'(dcm_rst_o), 0);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs",
                 int'({dcm_rst_o, sys_rst_o, locked_o, fail_o, retries_o}),
                 int'(8'b1100_0000));
        @(negedge clk);
        rst_n = 1'b1;
        wait_sig(2, 1'b1, 80, "post_reset_run", n);

        // restart_i beats a valid lock in WAIT_LOCK.
        pulse_restart();
        repeat (4) @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("restart_beats_lock", int'(dcm_rst_o), 1);

        // Timeout and lock on the same cycle: lock wins.
        locked = 1'b0;
        repeat (RC + TO - 3) @(negedge clk);
        locked = 1'b1;
        repeat (3) @(negedge clk);
        check("tie_retries", int'(retries_o), 0);
        check("tie_dcm_rst", int'(dcm_rst_o), 0);
        repeat (SC) @(negedge clk);
        check("tie_reaches_run", int'(locked_o), 1);

        // Random traffic against the model.
        for (int s = 0; s < 40; s++) begin
            int hold;
            hold   = $urandom_range(1, 120);
            locked = ($urandom_range(0, 9) < 7);
            status = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'h00;
            for (int c = 0; c < hold; c++) begin
                restart = ($urandom_range(0, 199) == 0);
                @(negedge clk);
            end
            restart = 1'b0;
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
